signal_analyzer: RTL and testbench

Measures the incoming sample stream produced by the waveform generators (triangle, positive/negative sawtooth, meander) and reports the current slope direction, the period between successive rising-slope onsets, and the per-period minimum and maximum. It sits on the consumer side of a generator-to-DSP path. Every accepted sample updates a small direction state machine, a saturating period counter and running min/max trackers. Results are latched and flagged with a one-cycle valid pulse.

---
 rtl/signal_analyzer.sv | 186 ++++++++++++++++++
 tb/tb_signal_analyzer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/signal_analyzer.sv
// signal_analyzer: measures an unsigned sample stream and reports slope direction, the period
// between successive rising-slope onsets, and the min/max over that period.
//
// Build option: define SIGNAL_ANALYZER_MINMAX_EN to build the min/max trackers; otherwise
// min_o/max_o are tied to zero and only direction and period logic remain.
//
// Ports:
//   clk_i          clock, rising edge
//   a_rst_i        asynchronous active-high reset
//   enable_i       sample-accept qualifier
//   clear_i        synchronous clear, overrides enable_i
//   signal_i       unsigned input sample
//   dir_o          slope state: 00 idle/flat, 01 rise, 10 fall
//   period_o       last measured period in accepted samples
//   min_o, max_o   min/max over the last measured period
//   period_valid_o one-cycle pulse when period_o/min_o/max_o update
//   overflow_o     sticky period-counter saturation flag
module signal_analyzer #(
    parameter int unsigned SIGNAL_WIDTH = 32,
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    a_rst_i,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic [SIGNAL_WIDTH-1:0] signal_i,
    output logic [1:0]              dir_o,
    output logic [PERIOD_WIDTH-1:0] period_o,
    output logic [SIGNAL_WIDTH-1:0] min_o,
    output logic [SIGNAL_WIDTH-1:0] max_o,
    output logic                    period_valid_o,
    output logic                    overflow_o
);

    localparam logic [PERIOD_WIDTH-1:0] CntMax = {PERIOD_WIDTH{1'b1}};

    typedef enum logic [1:0] {StIdle, StFlat, StRise, StFall} state_e;

    state_e                  state_q, state_d;
    logic [SIGNAL_WIDTH-1:0] prev_q, prev_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    armed_q, armed_d;
    logic                    ovf_q, ovf_d;
    logic                    valid_q, valid_d;
    logic                    rise_ev;

`ifdef SIGNAL_ANALYZER_MINMAX_EN
    logic [SIGNAL_WIDTH-1:0] run_min_q, run_min_d;
    logic [SIGNAL_WIDTH-1:0] run_max_q, run_max_d;
    logic [SIGNAL_WIDTH-1:0] min_q, min_d;
    logic [SIGNAL_WIDTH-1:0] max_q, max_d;
    logic [SIGNAL_WIDTH-1:0] win_min, win_max;

    // A zero count means the window is empty, so the current sample seeds the trackers.
    always_comb begin
        win_min = run_min_q;
        win_max = run_max_q;
        if (cnt_q == '0 || signal_i < run_min_q) win_min = signal_i;
        if (cnt_q == '0 || signal_i > run_max_q) win_max = signal_i;
    end

    always_comb begin
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        min_d     = min_q;
        max_d     = max_q;
        if (clear_i) begin
            run_min_d = '0;
            run_max_d = '0;
            min_d     = '0;
            max_d     = '0;
        end else if (enable_i) begin
            run_min_d = win_min;
            run_max_d = win_max;
            if (rise_ev && armed_q) begin
                min_d = win_min;
                max_d = win_max;
            end
        end
    end

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            run_min_q <= '0;
            run_max_q <= '0;
            min_q     <= '0;
            max_q     <= '0;
        end else begin
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
`else
    assign min_o = '0;
    assign max_o = '0;
`endif

    // Direction FSM, period counter and output latching.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        armed_d  = armed_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        rise_ev  = 1'b0;

        if (clear_i) begin
            state_d  = StIdle;
            prev_d   = '0;
            cnt_d    = '0;
            period_d = '0;
            armed_d  = 1'b0;
            ovf_d    = 1'b0;
        end else if (enable_i) begin
            prev_d = signal_i;
            if (cnt_q == CntMax) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + PERIOD_WIDTH'(1);
            end

            if (state_q == StIdle) begin
                state_d = StFlat;
            end else begin
                if (signal_i > prev_q) begin
                    state_d = StRise;
                end else if (signal_i < prev_q) begin
                    state_d = StFall;
                end else begin
                    state_d = StFlat;
                end
                rise_ev = (state_d == StRise) && (state_q != StRise);
            end

            if (rise_ev) begin
                if (armed_q) begin
                    period_d = cnt_d;
                    valid_d  = 1'b1;
                end
                cnt_d   = '0;
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            state_q  <= StIdle;
            prev_q   <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            armed_q  <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            armed_q  <= armed_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        unique case (state_q)
            StRise:  dir_o = 2'b01;
            StFall:  dir_o = 2'b10;
            default: dir_o = 2'b00;
        endcase
    end

    assign period_o       = period_q;
    assign period_valid_o = valid_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_signal_analyzer.sv
// Randomised and directed bench for signal_analyzer against a window-based reference model.
module tb_signal_analyzer;

    localparam int SW   = 8;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          a_rst = 1'b1;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic [SW-1:0] signal = '0;
    logic [1:0]    dir;
    logic [PW-1:0] period;
    logic [SW-1:0] min_v, max_v;
    logic          valid, ovf;

    signal_analyzer #(
        .SIGNAL_WIDTH(SW),
        .PERIOD_WIDTH(PW)
    ) dut (
        .clk_i         (clk),
        .a_rst_i       (a_rst),
        .enable_i      (enable),
        .clear_i       (clear),
        .signal_i      (signal),
        .dir_o         (dir),
        .period_o      (period),
        .min_o         (min_v),
        .max_o         (max_v),
        .period_valid_o(valid),
        .overflow_o    (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the current measurement window is kept as a list of samples.
    // m_state: 0 idle, 1 flat, 2 rise, 3 fall
    int          m_state;
    int unsigned m_prev, m_period, m_min, m_max;
    bit          m_armed, m_ovf, m_valid;
    int unsigned win[$];

    function automatic void model_reset();
        m_state = 0; m_prev = 0; m_period = 0; m_min = 0; m_max = 0;
        m_armed = 0; m_ovf = 0; m_valid = 0;
        win.delete();
    endfunction

    function automatic void model_step(bit en, bit clr, int unsigned s);
        int  ns;
        bit  ev;
        m_valid = 0;
        if (clr) begin
            model_reset();
        end else if (en) begin
            win.push_back(s);
            if (win.size() > PMAX) m_ovf = 1;
            if (m_state == 0) begin
                m_state = 1;
            end else begin
                ns = (s > m_prev) ? 2 : (s < m_prev) ? 3 : 1;
                ev = (ns == 2) && (m_state != 2);
                m_state = ns;
                if (ev) begin
                    if (m_armed) begin
                        m_period = (win.size() > PMAX) ? PMAX : win.size();
                        m_min = win[0];
                        m_max = win[0];
                        foreach (win[i]) begin
                            if (win[i] < m_min) m_min = win[i];
                            if (win[i] > m_max) m_max = win[i];
                        end
                        m_valid = 1;
                    end
                    m_armed = 1;
                    win.delete();
                end
            end
            m_prev = s;
        end
    endfunction

    task automatic check_all(input string tag);
        logic [1:0] exp_dir;
        exp_dir = (m_state == 2) ? 2'b01 : (m_state == 3) ? 2'b10 : 2'b00;
        check_val({tag, ".dir"}, 32'(dir), 32'(exp_dir));
        check_val({tag, ".period"}, 32'(period), m_period);
        check_val({tag, ".valid"}, 32'(valid), 32'(m_valid));
        check_val({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
`ifdef SIGNAL_ANALYZER_MINMAX_EN
        check_val({tag, ".min"}, 32'(min_v), m_min);
        check_val({tag, ".max"}, 32'(max_v), m_max);
`else
        check_val({tag, ".min"}, 32'(min_v), 32'd0);
        check_val({tag, ".max"}, 32'(max_v), 32'd0);
`endif
    endtask

    // Called at posedge+1; applies one cycle of inputs and checks the result after the edge.
    task automatic drive(input bit en, input bit clr, input int unsigned s, input string tag);
        int unsigned sm;
        sm     = s & ((1 << SW) - 1);
        enable = en;
        clear  = clr;
        signal = sm[SW-1:0];
        @(posedge clk);
        model_step(en, clr, sm);
        #1;
        check_all(tag);
    endtask

    int tri_seq[6] = '{0, 1, 2, 3, 2, 1};
    int valid_cnt;

    initial begin
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        check_all("reset_hold");

        // Positive sawtooth 0..7
        for (int i = 0; i < 40; i++) drive(1, 0, i % 8, "saw");

        // Triangle 0,1,2,3,2,1
        drive(1, 1, 0, "clr_tri");
        for (int i = 0; i < 30; i++) drive(1, 0, tri_seq[i % 6], "tri");

        // Meander 4x00 then 4xFF
        drive(1, 1, 0, "clr_mea");
        for (int i = 0; i < 32; i++) drive(1, 0, ((i / 4) % 2) ? 'hFF : 'h00, "mea");

        // Asynchronous reset mid-stream, asserted between edges
        for (int i = 0; i < 5; i++) drive(1, 0, i, "pre_rst");
        #2;
        a_rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        enable = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_held");
        a_rst = 1'b0;
        valid_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, i % 4, "post_rst");
            if (valid) valid_cnt++;
            // the first pulse needs two fresh rise events: 0,1 then 3->0->1
            if (i == 4) check_val("post_rst.no_early_valid", 32'(valid_cnt), 32'd0);
        end

        // Saturation: long constant run between two rise events
        drive(1, 1, 0, "clr_ovf");
        drive(1, 0, 0, "ovf");
        drive(1, 0, 1, "ovf");
        for (int i = 0; i < 40; i++) drive(1, 0, 2, "ovf_flat");
        drive(1, 0, 3, "ovf_ev");
        check_val("ovf.period_sat", 32'(period), PMAX);
        check_val("ovf.flag", 32'(ovf), 32'd1);
        for (int i = 0; i < 8; i++) drive(1, 0, i, "ovf_sticky");
        check_val("ovf.sticky", 32'(ovf), 32'd1);

        // Triangle with enable toggling and a clear mid-period
        drive(1, 1, 0, "clr_en");
        begin
            int k;
            k = 0;
            for (int i = 0; i < 120; i++) begin
                bit en;
                en = $urandom_range(0, 1);
                if (i == 60) begin
                    drive(en, 1, tri_seq[k % 6], "en_clr");
                    check_val("en_clr.ovf", 32'(ovf), 32'd0);
                end else begin
                    drive(en, 0, tri_seq[k % 6], "en_tri");
                end
                if (en && i != 60) k++;
            end
        end

        // Random segments: noisy small values, plateaus, ramps, random enable and clears
        for (int seg = 0; seg < 60; seg++) begin
            int mode;
            int unsigned base;
            mode = $urandom_range(0, 3);
            base = $urandom_range(0, 255);
            for (int i = 0; i < 20; i++) begin
                int unsigned v;
                bit en, clr;
                case (mode)
                    0:       v = $urandom_range(0, 3);
                    1:       v = base;
                    2:       v = base + i;
                    default: v = $urandom_range(0, 255);
                endcase
                en  = ($urandom_range(0, 9) < 8);
                clr = ($urandom_range(0, 99) == 0);
                drive(en, clr, v, "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
